// File: rtl/bin_to_bcd_seq_if.sv
// bin_to_bcd_seq_if: start/busy/done handshake and data bus for the BCD encoder
// master: drives start, bin; observes bcd, busy, done, overflow
// slave : the encoder side of the same signals
interface bin_to_bcd_seq_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic [4*DIGITS-1:0]   bcd;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    modport master (output start, bin, input bcd, busy, done, overflow);
    modport slave  (input start, bin, output bcd, busy, done, overflow);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD encoder, one bit per clock
// clk   : system clock, rising edge
// rst_n : asynchronous active-low reset
// bus   : slave side of bin_to_bcd_seq_if (start, bin in; bcd, busy, done, overflow out)
module bin_to_bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bin_to_bcd_seq_if.slave      bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t          state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [BW-1:0]    scr_q, scr_d, adj;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sticky_q, sticky_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    always_comb begin
        adj = scr_q;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = scr_q[4*i +: 4] >= 4'd5 ? scr_q[4*i +: 4] + 4'd3 : scr_q[4*i +: 4];
        state_d  = state_q;
        sh_d     = sh_q;
        scr_d    = scr_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        if (state_q == IDLE) begin
            if (bus.start) begin
                sh_d     = bus.bin;
                scr_d    = '0;
                sticky_d = 1'b0;
                cnt_d    = CW'(WIDTH);
                state_d  = SHIFT;
            end
        end else begin
            sh_d     = sh_q << 1;
            scr_d    = {adj[BW-2:0], sh_q[WIDTH-1]};
            // a digit carried out of the top means the value exceeds the display range
            sticky_d = sticky_q | adj[BW-1];
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                bcd_d   = scr_d;
                ovf_d   = sticky_d;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sh_q     <= '0;
            scr_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            scr_q    <= scr_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end
    assign bus.bcd      = bcd_q;
    assign bus.overflow = ovf_q;
    assign bus.done     = done_q;
    assign bus.busy     = state_q == SHIFT;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed and random checks of bin_to_bcd_seq against an arithmetic model
module tb_bin_to_bcd_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    bin_to_bcd_seq_if #(.WIDTH(16), .DIGITS(5)) bi ();
    bin_to_bcd_seq_if #(.WIDTH(8),  .DIGITS(2)) si ();
    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bi.slave));
    bin_to_bcd_seq #(.WIDTH(8),  .DIGITS(2)) dut_s (.clk(clk), .rst_n(rst_n), .bus(si.slave));
    int vectors = 0;
    int errs = 0;
    int sel = 0;
    logic [39:0] prev_b = '0;
    logic [39:0] prev_s = '0;
    logic o_done, o_busy, o_ovf;
    logic [39:0] o_bcd;
    always_comb begin
        o_done = sel != 0 ? si.done : bi.done;
        o_busy = sel != 0 ? si.busy : bi.busy;
        o_ovf  = sel != 0 ? si.overflow : bi.overflow;
        o_bcd  = sel != 0 ? 40'(si.bcd) : 40'(bi.bcd);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned p10(input int d);
        longint unsigned r = 1;
        for (int i = 0; i < d; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [39:0] ref_bcd(input longint unsigned v, input int d);
        logic [39:0] r = '0;
        longint unsigned x = v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic drive(input logic s, input logic [31:0] v);
        if (sel != 0) begin
            si.start = s;
            si.bin = v[7:0];
        end else begin
            bi.start = s;
            bi.bin = v[15:0];
        end
    endtask

    // one conversion on the selected DUT; optional bin change or extra start pulse mid-run
    task automatic run(input longint unsigned v, input int change_at, input int pulse_at, input logic [31:0] alt);
        int w = sel != 0 ? 8 : 16;
        int d = sel != 0 ? 2 : 5;
        logic [39:0] prev = sel != 0 ? prev_s : prev_b;
        logic [39:0] exp = ref_bcd(v, d);
        logic eovf = v >= p10(d);
        int dones = 0;
        int lat = 0;
        @(negedge clk);
        drive(1'b1, 32'(v));
        for (int cyc = 1; cyc <= w + 4; cyc++) begin
            @(negedge clk);
            if (cyc == 1) drive(1'b0, 32'(v));
            if (change_at > 0 && cyc == change_at) drive(1'b0, alt);
            if (pulse_at > 0 && cyc == pulse_at) drive(1'b1, alt);
            if (pulse_at > 0 && cyc == pulse_at + 1) drive(1'b0, alt);
            if (cyc == 2) begin
                check("busy_mid", 64'(o_busy), 64'(1));
                check("bcd_hold", 64'(o_bcd), 64'(prev));
            end
            if (o_done) begin
                dones++;
                if (lat == 0) lat = cyc;
                check("bcd", 64'(o_bcd), 64'(exp));
                check("overflow", 64'(o_ovf), 64'(eovf));
                check("busy_in_done", 64'(o_busy), 64'(0));
            end
        end
        check("latency", 64'(lat), 64'(w + 1));
        check("done_count", 64'(dones), 64'(1));
        if (sel != 0) prev_s = exp; else prev_b = exp;
    endtask

    initial begin
        int dones, first, second;
        bi.start = 1'b0; bi.bin = '0;
        si.start = 1'b0; si.bin = '0;
        repeat (2) @(negedge clk);
        check("rst_bcd", 64'(bi.bcd), 64'(0));
        check("rst_busy", 64'(bi.busy), 64'(0));
        check("rst_done", 64'(bi.done), 64'(0));
        check("rst_ovf", 64'(bi.overflow), 64'(0));
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_bcd", 64'(bi.bcd), 64'(0));
        check("idle_busy", 64'(bi.busy), 64'(0));
        check("idle_done", 64'(bi.done), 64'(0));
        check("idle_ovf", 64'(bi.overflow), 64'(0));
        sel = 0;
        run(0, 0, 0, 0);
        run(1234, 0, 0, 0);
        run(65535, 0, 0, 0);
        run(100, 5, 0, 999);
        run(555, 0, 4, 7);
        for (int k = 0; k < 20; k++) run(longint'($urandom_range(0, 65535)), 0, 0, 0);
        // start held high: bin=9 accepted, then bin=10 accepted during the done cycle
        dones = 0; first = 0; second = 0;
        @(negedge clk);
        bi.start = 1'b1; bi.bin = 16'd9;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) bi.bin = 16'd10;
            if (bi.done) begin
                dones++;
                if (dones == 1) begin
                    first = cyc;
                    check("hs_bcd1", 64'(bi.bcd), 64'(ref_bcd(9, 5)));
                end else begin
                    second = cyc;
                    check("hs_bcd2", 64'(bi.bcd), 64'(ref_bcd(10, 5)));
                    bi.start = 1'b0;
                    break;
                end
            end
        end
        bi.start = 1'b0;
        check("hs_first", 64'(first), 64'(17));
        check("hs_second", 64'(second), 64'(34));
        check("hs_dones", 64'(dones), 64'(2));
        @(negedge clk);
        check("hs_idle", 64'(bi.busy), 64'(0));
        prev_b = ref_bcd(10, 5);
        // reset in the middle of converting 4321
        @(negedge clk);
        bi.start = 1'b1; bi.bin = 16'd4321;
        @(negedge clk);
        bi.start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_bcd", 64'(bi.bcd), 64'(0));
        check("mid_rst_busy", 64'(bi.busy), 64'(0));
        check("mid_rst_done", 64'(bi.done), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (bi.done) dones++;
        end
        check("mid_rst_nodone", 64'(dones), 64'(0));
        check("mid_rst_bcd_held", 64'(bi.bcd), 64'(0));
        prev_b = '0;
        prev_s = '0;
        run(42, 0, 0, 0);
        sel = 1;
        run(255, 0, 0, 0);
        run(99, 0, 0, 0);
        run(100, 0, 0, 0);
        for (int k = 0; k < 15; k++) run(longint'($urandom_range(0, 255)), 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
